// File: rtl/amp_peak_meter.sv
// amp_peak_meter: peak-hold level meter for the LED VU display.
// Samples a 9-bit amplitude on smpl_vld and keeps a peak value that is held
// for HOLD_TICKS tick pulses and then decays linearly by DECAY_STEP per tick.
// Ports:
//   clk, rst_n      - rising-edge clock, synchronous active-low reset
//   smpl_vld, amp   - amplitude sample strobe and unsigned magnitude
//   tick            - hold/decay timebase pulse
//   clr_clip        - clears the sticky clip flag
//   peak            - registered peak-hold value
//   bar             - registered 8-segment thermometer derived from peak
//   clip            - registered sticky clip indicator
module amp_peak_meter #(
  parameter int unsigned HOLD_TICKS = 16,
  parameter int unsigned DECAY_STEP = 8,
  parameter int unsigned CLIP_THR   = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       smpl_vld,
  input  logic [8:0] amp,
  input  logic       tick,
  input  logic       clr_clip,
  output logic [8:0] peak,
  output logic [7:0] bar,
  output logic       clip
);

  localparam int unsigned AMP_W  = 9;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned BAR_W  = 8;
  localparam int unsigned SEG    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [AMP_W-1:0]    peak_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [BAR_W-1:0]    bar_nxt;
  logic                clip_nxt;
  logic                capture;

  // State, peak, hold counter, bar and clip registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      peak     <= '0;
      hold_cnt <= '0;
      bar      <= '0;
      clip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      peak     <= peak_nxt;
      hold_cnt <= hold_nxt;
      bar      <= bar_nxt;
      clip     <= clip_nxt;
    end
  end

  // Next-state: capture beats tick; tick drives hold countdown then decay
  always_comb begin
    state_nxt = state;
    peak_nxt  = peak;
    hold_nxt  = hold_cnt;
    capture   = smpl_vld && (amp >= peak);

    if (capture) begin
      peak_nxt  = amp;
      hold_nxt  = HOLD_W'(HOLD_TICKS);
      state_nxt = HOLD;
    end else if (tick) begin
      unique case (state)
        HOLD: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            hold_nxt  = '0;
            state_nxt = DECAY;
          end else begin
            hold_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        DECAY: begin
          // Saturate at zero rather than wrapping
          if (peak > AMP_W'(DECAY_STEP)) begin
            peak_nxt = peak - AMP_W'(DECAY_STEP);
          end else begin
            peak_nxt  = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Thermometer from the registered peak, giving the extra cycle of latency
  always_comb begin
    bar_nxt = '0;
    for (int i = 0; i < int'(BAR_W); i++) begin
      bar_nxt[i] = ({1'b0, peak} > 10'(SEG * i));
    end
  end

  // Sticky clip: a new clipping sample outranks a same-cycle clear
  always_comb begin
    clip_nxt = clip;
    if (smpl_vld && (amp >= AMP_W'(CLIP_THR))) begin
      clip_nxt = 1'b1;
    end else if (clr_clip) begin
      clip_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_amp_peak_meter.sv
// tb_amp_peak_meter: directed and randomized checks of amp_peak_meter
// against a behavioural peak-meter model.
module tb_amp_peak_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       smpl_vld;
  logic [8:0] amp;
  logic       tick;
  logic       clr_clip;
  logic [8:0] peak;
  logic [7:0] bar;
  logic       clip;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0=idle, 1=holding, 2=decaying
  int m_peak  = 0;
  int m_left  = 0;
  int m_mode  = 0;
  int m_bar   = 0;
  int m_clip  = 0;

  amp_peak_meter #(.HOLD_TICKS(16), .DECAY_STEP(8), .CLIP_THR(480)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl_vld (smpl_vld),
    .amp      (amp),
    .tick     (tick),
    .clr_clip (clr_clip),
    .peak     (peak),
    .bar      (bar),
    .clip     (clip)
  );

  always #5 clk = ~clk;

  // Number of lit segments is ceil(level/64); bar is that many low ones
  function automatic int bar_of(input int level);
    int n;
    n = (level + 63) / 64;
    if (n > 8) n = 8;
    return (1 << n) - 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit v, input int a, input bit t, input bit c, input bit r);
    if (!r) begin
      m_peak = 0; m_left = 0; m_mode = 0; m_bar = 0; m_clip = 0;
      return;
    end
    m_bar = bar_of(m_peak);
    if (v && a >= 480) m_clip = 1;
    else if (c) m_clip = 0;
    if (v && a >= m_peak) begin
      m_peak = a; m_left = 16; m_mode = 1;
    end else if (t && m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
    end else if (t && m_mode == 2) begin
      m_peak = (m_peak > 8) ? m_peak - 8 : 0;
      if (m_peak == 0) m_mode = 0;
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge
  task automatic step(input bit v, input int a, input bit t, input bit c, input bit r = 1'b1);
    smpl_vld = v; amp = 9'(a); tick = t; clr_clip = c; rst_n = r;
    @(posedge clk);
    model(v, a, t, c, r);
    #1;
    chk("peak", int'(peak), m_peak);
    chk("bar",  int'(bar),  m_bar);
    chk("clip", int'(clip), m_clip);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; smpl_vld = 1'b0; amp = '0; tick = 1'b0; clr_clip = 1'b0;
    @(posedge clk); #1;

    // Reset under random activity
    step(1'b1, int'($urandom_range(511)), 1'b1, 1'b0, 1'b0);
    step(1'b1, int'($urandom_range(511)), 1'b1, 1'b1, 1'b0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_bar", int'(bar), 0);
    chk("rst_clip", int'(clip), 0);
    step(1'b1, 300, 1'b0, 1'b0);
    chk("cap300_peak", int'(peak), 300);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("cap300_bar", int'(bar), 8'h1F);

    // Hold timing
    do_reset();
    step(1'b1, 200, 1'b0, 1'b0);
    ticks(15);
    chk("hold15_peak", int'(peak), 200);
    ticks(1);
    chk("hold16_peak", int'(peak), 200);
    ticks(1);
    chk("decay1_peak", int'(peak), 192);

    // Decay saturation to zero
    do_reset();
    step(1'b1, 20, 1'b0, 1'b0);
    ticks(16);
    ticks(1); chk("sat_12", int'(peak), 12);
    ticks(1); chk("sat_4", int'(peak), 4);
    ticks(1); chk("sat_0", int'(peak), 0);
    ticks(1); chk("sat_bar", int'(bar), 0);
    ticks(3); chk("sat_stay0", int'(peak), 0);

    // Capture priority while decaying
    do_reset();
    step(1'b1, 158, 1'b0, 1'b0);
    ticks(17);
    chk("pri_150", int'(peak), 150);
    step(1'b1, 100, 1'b0, 1'b0);
    chk("pri_ignore", int'(peak), 150);
    step(1'b1, 150, 1'b1, 1'b0);
    chk("pri_coinc", int'(peak), 150);
    ticks(16);
    chk("pri_reload_hold", int'(peak), 150);
    ticks(1);
    chk("pri_reload_decay", int'(peak), 142);

    // Clip threshold, clear and set-over-clear
    do_reset();
    step(1'b1, 479, 1'b0, 1'b0); chk("clip_479", int'(clip), 0);
    step(1'b1, 480, 1'b0, 1'b0); chk("clip_480", int'(clip), 1);
    ticks(40);                    chk("clip_decay", int'(clip), 1);
    step(1'b0, 0, 1'b0, 1'b1);   chk("clip_clr", int'(clip), 0);
    step(1'b1, 511, 1'b0, 1'b1); chk("clip_setwins", int'(clip), 1);

    // Reset mid-decay with a competing capture
    do_reset();
    step(1'b1, 308, 1'b0, 1'b0);
    ticks(17);
    chk("mid_300", int'(peak), 300);
    step(1'b1, 400, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_peak", int'(peak), 0);
    chk("mid_rst_clip", int'(clip), 0);
    ticks(2);
    chk("mid_idle", int'(peak), 0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("mid_bar", int'(bar), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(3) == 0), int'($urandom_range(511)),
           ($urandom_range(1) == 0), ($urandom_range(15) == 0),
           ($urandom_range(199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
